mem_dump_reader: RTL and testbench

MEM_DUMP_READER -- requirements
Module: mem_dump_reader

---
 rtl/mem_dump_reader.sv | 104 ++++++++++
 tb/tb_mem_dump_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
// Streams a block of words from a single-cycle-latency RAM to a ready/valid consumer.
// States: IDLE wait for start | READ drive memRead | WAIT capture memData | OUTPUT hold word until ready | DONE one-cycle done pulse
module mem_dump_reader #(
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned COUNT_WIDTH = 9
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [31:0]            baseAddr_i,
  input  logic [COUNT_WIDTH-1:0] wordCount_i,
  output logic [31:0]            memAddr_o,
  output logic                   memRead_o,
  input  logic [31:0]            memData_i,
  output logic [31:0]            outData_o,
  output logic [31:0]            outAddr_o,
  output logic                   outValid_o,
  input  logic                   outReady_i,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            addr_q, addr_d;
  logic [COUNT_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]            out_data_q, out_data_d;
  logic [31:0]            out_addr_q, out_addr_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          if (wordCount_i != '0) begin
            addr_d  = baseAddr_i;
            rem_d   = wordCount_i;
            state_d = S_READ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        out_data_d = memData_i;
        out_addr_d = addr_q;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (outReady_i) begin
          if (rem_q == COUNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem_q - COUNT_WIDTH'(1);
            addr_d  = addr_q + 32'(ADDR_STEP);
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort wins over acceptance and the DONE exit alike
    if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  assign memAddr_o  = addr_q;
  assign memRead_o  = (state_q == S_READ);
  assign outData_o  = out_data_q;
  assign outAddr_o  = out_addr_q;
  assign outValid_o = (state_q == S_OUTPUT);
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader: a behavioural RAM plus a word-list/latency model of each dump.
module tb_mem_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [31:0] base_addr, mem_addr, mem_data, out_data, out_addr;
  logic [8:0]  word_count;
  logic        mem_read, out_valid, busy, done;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  mem_dump_reader #(.ADDR_STEP(4), .COUNT_WIDTH(9)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .baseAddr_i(base_addr), .wordCount_i(word_count),
    .memAddr_o(mem_addr), .memRead_o(mem_read), .memData_i(mem_data),
    .outData_o(out_data), .outAddr_o(out_addr), .outValid_o(out_valid),
    .outReady_i(out_ready), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h20100002;
      32'h4:   return 32'h22100003;
      default: return {a[15:0], ~a[31:16]} ^ 32'h5A5A1234;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_read) begin
      mem_data <= ram_word(mem_addr);
      rd_cnt   <= rd_cnt + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  // Runs one dump; latencies are relative to the edge that samples start.
  task automatic run_dump(input logic [31:0] base, input int cnt, input int stall_pct,
                          input int hold_first, input int abort_word, input bit junk,
                          output int start_cyc, output int done_cyc, output int first_rd,
                          output int first_val, output int stalls, output int reads,
                          output int done_pulses, output int unstable, output bit timeout);
    int rd0, held;
    bit have_prev, aborting, rdy, finished;
    logic [31:0] prev_d, prev_a;
    got_addr.delete();
    got_data.delete();
    done_cyc = -1; first_rd = -1; first_val = -1;
    stalls = 0; done_pulses = 0; unstable = 0; held = 0;
    have_prev = 0; aborting = 0; finished = 0;
    prev_d = '0; prev_a = '0;
    rd0 = rd_cnt;
    base_addr = base;
    word_count = 9'(cnt);
    start = 1'b1;
    out_ready = 1'b0;
    cyc();
    start_cyc = cyc_cnt;
    for (int k = 0; k < 400; k++) begin
      if (junk) begin
        start = 1'($urandom_range(1));
        base_addr = $urandom;
        word_count = 9'($urandom);
      end else begin
        start = 1'b0;
      end
      if (mem_read && first_rd < 0) first_rd = cyc_cnt - start_cyc;
      if (out_valid) begin
        if (first_val < 0) first_val = cyc_cnt - start_cyc;
        if (have_prev && (out_data !== prev_d || out_addr !== prev_a)) unstable++;
        if (got_addr.size() == 0 && held < hold_first) rdy = 1'b0;
        else rdy = ($urandom_range(99) >= stall_pct);
        if (got_addr.size() == 0) held++;
        if (abort_word > 0 && got_addr.size() == abort_word - 1) begin
          abort = 1'b1;
          rdy = 1'b1;
          aborting = 1'b1;
        end
        out_ready = rdy;
        if (rdy && !aborting) begin
          got_addr.push_back(out_addr);
          got_data.push_back(out_data);
          have_prev = 1'b0;
        end else if (!rdy) begin
          stalls++;
          have_prev = 1'b1;
          prev_d = out_data;
          prev_a = out_addr;
        end
      end else begin
        out_ready = 1'($urandom_range(1));
        have_prev = 1'b0;
      end
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc_cnt - start_cyc;
      end
      if (done_cyc >= 0 || aborting) begin
        cyc();
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        if (done) done_pulses++;
        finished = 1'b1;
        break;
      end
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    timeout = !finished;
    reads = rd_cnt - rd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0;
    repeat (3) cyc();
    vectors++; if ({mem_addr, out_data, out_addr} !== 96'h0) begin miscompares++; $display("FAIL reset_data: got %h %h %h exp 0", mem_addr, out_data, out_addr); end
    vectors++; if ({mem_read, out_valid, busy, done} !== 4'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b exp 0000", {mem_read, out_valid, busy, done}); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) cyc();
    vectors++; if ({mem_read, out_valid, busy, done} !== 4'b0) begin miscompares++; $display("FAIL reset_release: got %b exp 0000", {mem_read, out_valid, busy, done}); end
  endtask

  task automatic test_basic();
    int sc, dc, fr, fv, st, rd, dp, un;
    bit to;
    run_dump(32'h0, 2, 0, 0, 0, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %0d exp 0", to); end
    vectors++; if (got_addr.size() !== 2) begin miscompares++; $display("FAIL basic_nwords: got %0d exp 2", got_addr.size()); end
    if (got_addr.size() == 2) begin
      vectors++; if (got_addr[0] !== 32'h0 || got_data[0] !== 32'h20100002) begin miscompares++; $display("FAIL basic_word0: got %h/%h exp 0/20100002", got_addr[0], got_data[0]); end
      vectors++; if (got_addr[1] !== 32'h4 || got_data[1] !== 32'h22100003) begin miscompares++; $display("FAIL basic_word1: got %h/%h exp 4/22100003", got_addr[1], got_data[1]); end
    end
    vectors++; if (dc !== 6) begin miscompares++; $display("FAIL basic_done_lat: got %0d exp 6", dc); end
    vectors++; if (fr !== 0 || fv !== 2) begin miscompares++; $display("FAIL basic_latency: got rd %0d val %0d exp 0 2", fr, fv); end
    vectors++; if (rd !== 2 || dp !== 1) begin miscompares++; $display("FAIL basic_counts: got reads %0d done %0d exp 2 1", rd, dp); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle: got busy %b exp 0", busy); end
  endtask

  task automatic test_stall();
    int sc, dc, fr, fv, st, rd, dp, un;
    bit to;
    run_dump(32'h0, 2, 0, 5, 0, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (to !== 1'b0 || got_addr.size() !== 2) begin miscompares++; $display("FAIL stall_nwords: got %0d exp 2", got_addr.size()); end
    if (got_addr.size() == 2) begin
      vectors++; if (got_data[0] !== 32'h20100002 || got_data[1] !== 32'h22100003) begin miscompares++; $display("FAIL stall_data: got %h %h exp 20100002 22100003", got_data[0], got_data[1]); end
    end
    vectors++; if (un !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes exp 0", un); end
    vectors++; if (st !== 5 || dc !== 11) begin miscompares++; $display("FAIL stall_timing: got stalls %0d done %0d exp 5 11", st, dc); end
    vectors++; if (rd !== 2 || dp !== 1) begin miscompares++; $display("FAIL stall_counts: got reads %0d done %0d exp 2 1", rd, dp); end
  endtask

  task automatic test_zero();
    int sc, dc, fr, fv, st, rd, dp, un;
    bit to;
    run_dump(32'h80, 0, 0, 0, 0, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (dc !== 0 || dp !== 1) begin miscompares++; $display("FAIL zero_done: got lat %0d pulses %0d exp 0 1", dc, dp); end
    vectors++; if (rd !== 0 || fv !== -1) begin miscompares++; $display("FAIL zero_access: got reads %0d valid %0d exp 0 -1", rd, fv); end
  endtask

  task automatic test_wrap();
    int sc, dc, fr, fv, st, rd, dp, un;
    bit to;
    run_dump(32'hFFFFFFFC, 2, 0, 0, 0, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (got_addr.size() !== 2) begin miscompares++; $display("FAIL wrap_nwords: got %0d exp 2", got_addr.size()); end
    if (got_addr.size() == 2) begin
      vectors++; if (got_addr[0] !== 32'hFFFFFFFC || got_addr[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h %h exp fffffffc 0", got_addr[0], got_addr[1]); end
      vectors++; if (got_data[1] !== 32'h20100002) begin miscompares++; $display("FAIL wrap_data: got %h exp 20100002", got_data[1]); end
    end
  endtask

  task automatic test_random();
    int sc, dc, fr, fv, st, rd, dp, un, cnt;
    bit to;
    logic [31:0] base, ea;
    for (int t = 0; t < 8; t++) begin
      base = $urandom & 32'hFFFFFFFC;
      if (t == 0) base = 32'hFFFFFFF0;
      cnt = $urandom_range(6, 1);
      run_dump(base, cnt, 35, 0, 0, 1'b1, sc, dc, fr, fv, st, rd, dp, un, to);
      vectors++; if (got_addr.size() !== cnt) begin miscompares++; $display("FAIL rand%0d_nwords: got %0d exp %0d", t, got_addr.size(), cnt); end
      for (int i = 0; i < got_addr.size() && i < cnt; i++) begin
        ea = base + 32'(4 * i);
        vectors++; if (got_addr[i] !== ea || got_data[i] !== ram_word(ea)) begin miscompares++; $display("FAIL rand%0d_word%0d: got %h/%h exp %h/%h", t, i, got_addr[i], got_data[i], ea, ram_word(ea)); end
      end
      vectors++; if (dc !== 3 * cnt + st) begin miscompares++; $display("FAIL rand%0d_done_lat: got %0d exp %0d", t, dc, 3 * cnt + st); end
      vectors++; if (rd !== cnt || dp !== 1 || un !== 0) begin miscompares++; $display("FAIL rand%0d_counts: got reads %0d done %0d unstable %0d exp %0d 1 0", t, rd, dp, un, cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand%0d_idle: got busy %b exp 0", t, busy); end
    end
  endtask

  task automatic test_abort();
    int sc, dc, fr, fv, st, rd, dp, un;
    bit to;
    run_dump(32'h200, 4, 0, 0, 2, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (to !== 1'b0 || got_addr.size() !== 1) begin miscompares++; $display("FAIL abort_nwords: got %0d exp 1", got_addr.size()); end
    vectors++; if ({busy, out_valid, done} !== 3'b000 || dp !== 0) begin miscompares++; $display("FAIL abort_idle: got %b pulses %0d exp 000 0", {busy, out_valid, done}, dp); end
    vectors++; if (rd !== 2) begin miscompares++; $display("FAIL abort_reads: got %0d exp 2", rd); end
    repeat (2) cyc();
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL abort_quiet: got %b exp 00", {busy, done}); end
    run_dump(32'h100, 3, 0, 0, 0, 1'b0, sc, dc, fr, fv, st, rd, dp, un, to);
    vectors++; if (got_addr.size() !== 3 || dc !== 9 || dp !== 1) begin miscompares++; $display("FAIL abort_restart: got %0d words lat %0d exp 3 9", got_addr.size(), dc); end
    if (got_addr.size() == 3) begin
      vectors++; if (got_addr[2] !== 32'h108 || got_data[2] !== ram_word(32'h108)) begin miscompares++; $display("FAIL abort_restart_word: got %h/%h exp 108/%h", got_addr[2], got_data[2], ram_word(32'h108)); end
    end
  endtask

  task automatic test_abort_idle();
    base_addr = 32'h300; word_count = 9'd3;
    start = 1'b1; abort = 1'b1;
    cyc();
    vectors++; if ({busy, mem_read} !== 2'b00) begin miscompares++; $display("FAIL abort_start_prio: got %b exp 00", {busy, mem_read}); end
    start = 1'b0;
    cyc();
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL abort_in_idle: got %b exp 00", {busy, done}); end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rd0;
    base_addr = 32'h40; word_count = 9'd3; start = 1'b1; out_ready = 1'b1;
    cyc();
    start = 1'b0;
    vectors++; if (mem_read !== 1'b1 || mem_addr !== 32'h40) begin miscompares++; $display("FAIL rmid_read: got %b %h exp 1 40", mem_read, mem_addr); end
    cyc();
    vectors++; if ({busy, mem_read, out_valid} !== 3'b100) begin miscompares++; $display("FAIL rmid_wait: got %b exp 100", {busy, mem_read, out_valid}); end
    rd0 = rd_cnt;
    #2;
    reset = 1'b1;
    #1;
    vectors++; if ({mem_addr, out_data, out_addr} !== 96'h0 || {mem_read, out_valid, busy, done} !== 4'b0) begin miscompares++; $display("FAIL rmid_async: got %h %h %h %b exp all 0", mem_addr, out_data, out_addr, {mem_read, out_valid, busy, done}); end
    start = 1'b1;
    repeat (3) cyc();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_start_held: got busy %b exp 0", busy); end
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (8) begin
      cyc();
      vectors++; if ({busy, done, out_valid} !== 3'b000) begin miscompares++; $display("FAIL rmid_after: got %b exp 000", {busy, done, out_valid}); end
    end
    vectors++; if (rd_cnt !== rd0) begin miscompares++; $display("FAIL rmid_reads: got %0d exp %0d", rd_cnt, rd0); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_abort();
    test_abort_idle();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
